// File: rtl/cavlc_pkg.sv
// CAVLC run_before shared definitions.
// State encoding, widths and the run_before codeword table.
package cavlc_pkg;

    localparam int COEF_W = 15;
    localparam int CODE_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } state_t;

    // Indexed [zerosLeft saturated at 7][run]; unused pairs are zero.
    localparam int RB_BITS [8][16] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{3, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{3, 2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{3, 0, 1, 3, 2, 5, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{7, 6, 5, 4, 3, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0}
    };

    localparam int RB_LEN [8][16] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{2, 2, 2, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{2, 3, 3, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0},
        '{3, 3, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9, 10, 11, 0}
    };

endpackage

// File: rtl/cavlc_runbefore_lut.sv
// run_before codeword lookup.
// Pure combinational (zerosLeft, run) -> (code, length).
module cavlc_runbefore_lut
    import cavlc_pkg::*;
(
    input  logic [2:0]        zl,
    input  logic [3:0]        run,
    output logic [CODE_W-1:0] code_bit,
    output logic [3:0]        code_len
);

    // Table read, right-aligned codeword.
    always_comb begin
        code_bit = CODE_W'(RB_BITS[zl][run]);
        code_len = 4'(RB_LEN[zl][run]);
    end

endmodule

// File: rtl/cavlc_runbefore.sv
// CAVLC run_before encoder stage.
// Emits one run_before codeword per cycle over valid/ready.
module cavlc_runbefore
    import cavlc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        totalcoeff,
    input  logic [3:0]        totalzero,
    input  logic [3:0]        rightmost_idx,
    input  logic [COEF_W-1:0] din_00,
    input  logic [COEF_W-1:0] din_01,
    input  logic [COEF_W-1:0] din_02,
    input  logic [COEF_W-1:0] din_03,
    input  logic [COEF_W-1:0] din_04,
    input  logic [COEF_W-1:0] din_05,
    input  logic [COEF_W-1:0] din_06,
    input  logic [COEF_W-1:0] din_07,
    input  logic [COEF_W-1:0] din_08,
    input  logic [COEF_W-1:0] din_09,
    input  logic [COEF_W-1:0] din_10,
    input  logic [COEF_W-1:0] din_11,
    input  logic [COEF_W-1:0] din_12,
    input  logic [COEF_W-1:0] din_13,
    input  logic [COEF_W-1:0] din_14,
    input  logic [COEF_W-1:0] din_15,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_bit,
    output logic [3:0]        code_len,
    output logic              done
);

    state_t      state;
    logic [15:0] mask;
    logic [3:0]  pos;
    logic [3:0]  zl;
    logic [4:0]  rem;

    logic [15:0] din_mask;
    logic        idle;
    logic [15:0] cur_mask;
    logic [3:0]  cur_pos;
    logic [3:0]  cur_zl;
    logic [4:0]  cur_rem;
    logic [15:0] shifted;
    logic [3:0]  run;
    logic        found;
    logic [2:0]  zl_sat;
    logic [3:0]  nxt_zl;
    logic [3:0]  nxt_pos;
    logic [4:0]  nxt_rem;
    logic        emit;
    logic [CODE_W-1:0] lut_bit;
    logic [3:0]  lut_len;

    assign din_mask[0]  = din_00 != '0;
    assign din_mask[1]  = din_01 != '0;
    assign din_mask[2]  = din_02 != '0;
    assign din_mask[3]  = din_03 != '0;
    assign din_mask[4]  = din_04 != '0;
    assign din_mask[5]  = din_05 != '0;
    assign din_mask[6]  = din_06 != '0;
    assign din_mask[7]  = din_07 != '0;
    assign din_mask[8]  = din_08 != '0;
    assign din_mask[9]  = din_09 != '0;
    assign din_mask[10] = din_10 != '0;
    assign din_mask[11] = din_11 != '0;
    assign din_mask[12] = din_12 != '0;
    assign din_mask[13] = din_13 != '0;
    assign din_mask[14] = din_14 != '0;
    assign din_mask[15] = din_15 != '0;

    // In IDLE the first codeword is taken straight from the block inputs,
    // so it appears the cycle after start.
    assign idle     = state == IDLE;
    assign cur_mask = idle ? din_mask : mask;
    assign cur_pos  = idle ? rightmost_idx : pos;
    assign cur_zl   = idle ? totalzero : zl;
    assign cur_rem  = idle ? totalcoeff - 5'd1 : rem;

    // Count zero mask bits below pos (bit pos lands at bit 15).
    always_comb begin
        shifted = cur_mask << (4'd15 - cur_pos);
        run     = '0;
        found   = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            if (!found) begin
                if (shifted[i]) found = 1'b1;
                else            run   = run + 4'd1;
            end
        end
    end

    assign zl_sat  = (cur_zl > 4'd7) ? 3'd7 : cur_zl[2:0];
    assign nxt_zl  = cur_zl - run;
    assign nxt_pos = cur_pos - run - 4'd1;
    assign nxt_rem = cur_rem - 5'd1;

    assign emit = (idle && start && totalcoeff > 5'd1 && totalzero != 4'd0)
               || (state == EMIT && (!out_valid || out_ready));

    cavlc_runbefore_lut u_lut (
        .zl       (zl_sat),
        .run      (run),
        .code_bit (lut_bit),
        .code_len (lut_len)
    );

    // Block sequencing, codeword register and handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mask      <= '0;
            pos       <= '0;
            zl        <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            code_bit  <= '0;
            code_len  <= '0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mask  <= din_mask;
                        pos   <= rightmost_idx;
                        zl    <= totalzero;
                        rem   <= totalcoeff - 5'd1;
                        state <= FIN;
                    end
                end
                EMIT: ;
                FIN: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (emit) begin
                code_bit  <= lut_bit;
                code_len  <= lut_len;
                out_valid <= 1'b1;
                busy      <= 1'b1;
                zl        <= nxt_zl;
                pos       <= nxt_pos;
                rem       <= nxt_rem;
                if (nxt_zl == 4'd0 || nxt_rem == 5'd0) state <= FIN;
                else                                   state <= EMIT;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_runbefore.sv
// Directed bench for cavlc_runbefore.
// Vector table of blocks plus reset, backpressure and restart sequences.
module tb_cavlc_runbefore;
    import cavlc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [4:0] totalcoeff = '0;
    logic [3:0] totalzero = '0;
    logic [3:0] rightmost_idx = '0;
    logic [COEF_W-1:0] din [16];
    logic busy, out_valid, done;
    logic [CODE_W-1:0] code_bit;
    logic [3:0] code_len;

    cavlc_runbefore dut (
        .clk (clk), .rst (rst), .start (start),
        .totalcoeff (totalcoeff), .totalzero (totalzero),
        .rightmost_idx (rightmost_idx),
        .din_00 (din[0]),  .din_01 (din[1]),  .din_02 (din[2]),
        .din_03 (din[3]),  .din_04 (din[4]),  .din_05 (din[5]),
        .din_06 (din[6]),  .din_07 (din[7]),  .din_08 (din[8]),
        .din_09 (din[9]),  .din_10 (din[10]), .din_11 (din[11]),
        .din_12 (din[12]), .din_13 (din[13]), .din_14 (din[14]),
        .din_15 (din[15]),
        .busy (busy), .out_valid (out_valid), .out_ready (out_ready),
        .code_bit (code_bit), .code_len (code_len), .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tc;
        int tz;
        int ri;
        int coef [16];
        int n;
        int eb [8];
        int el [8];
    } vec_t;

    vec_t vecs [7];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input int v);
        totalcoeff    = vecs[v].tc[4:0];
        totalzero     = vecs[v].tz[3:0];
        rightmost_idx = vecs[v].ri[3:0];
        for (int i = 0; i < 16; i++) din[i] = vecs[v].coef[i][COEF_W-1:0];
    endtask

    // Runs one block; bp toggles out_ready, restart pulses start with done.
    task automatic run_block(input int v, input bit bp, input bit restart);
        int k = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        int hb = 0;
        int hl = 0;
        bit fin = 1'b0;
        apply(v);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk($sformatf("v%0d first_valid", v), out_valid, vecs[v].n > 0);
        chk($sformatf("v%0d busy_c1", v), busy, vecs[v].n > 0);
        while (!fin) begin
            out_ready = bp ? (cyc % 2 == 0) : 1'b1;
            if (stalled) begin
                chk($sformatf("v%0d hold_valid", v), out_valid, 1);
                chk($sformatf("v%0d hold_bits", v), code_bit, hb);
                chk($sformatf("v%0d hold_len", v), code_len, hl);
            end
            stalled = 1'b0;
            if (done) begin
                chk($sformatf("v%0d count", v), k, vecs[v].n);
                chk($sformatf("v%0d busy_done", v), busy, 0);
                if (vecs[v].n == 0)
                    chk($sformatf("v%0d done_cyc", v), cyc, 2);
                fin = 1'b1;
            end else if (out_valid) begin
                if (out_ready) begin
                    if (k < 8) begin
                        chk($sformatf("v%0d cw%0d_bits", v, k), code_bit, vecs[v].eb[k]);
                        chk($sformatf("v%0d cw%0d_len", v, k), code_len, vecs[v].el[k]);
                    end
                    k++;
                end else begin
                    stalled = 1'b1;
                    hb = code_bit;
                    hl = code_len;
                end
            end
            if (!fin) begin
                if (cyc > 60) begin
                    chk($sformatf("v%0d timeout", v), 0, 1);
                    fin = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        end
        if (restart) begin
            apply(0);
            start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d done_pulse", v), done, 0);
        if (restart) begin
            chk("restart_ignored_valid", out_valid, 0);
            chk("restart_ignored_busy", busy, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) din[i] = '0;
        // Block A
        vecs[0].tc = 9; vecs[0].tz = 5; vecs[0].ri = 13;
        vecs[0].coef = '{3, 0, 61, 20, 0, 8, 0, 56, 0, 0, 52, 1, 50, 46, 0, 0};
        vecs[0].n = 8;
        vecs[0].eb = '{3, 3, 3, 3, 2, 1, 1, 0};
        vecs[0].el = '{2, 2, 2, 3, 2, 2, 1, 1};
        // Block B
        vecs[1].tc = 6; vecs[1].tz = 6; vecs[1].ri = 11;
        vecs[1].coef = '{0, 0, 8, 0, 61, 0, 56, 0, 20, 0, 1, 46, 0, 0, 0, 0};
        vecs[1].n = 5;
        vecs[1].eb = '{3, 0, 2, 2, 2, 0, 0, 0};
        vecs[1].el = '{2, 3, 2, 2, 2, 0, 0, 0};
        // Long run of 14 zeros
        vecs[2].tc = 2; vecs[2].tz = 14; vecs[2].ri = 15;
        vecs[2].coef = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7};
        vecs[2].n = 1;
        vecs[2].eb = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].el = '{11, 0, 0, 0, 0, 0, 0, 0};
        // zl=8 saturates to the >6 row, run 8 -> 00001
        vecs[3].tc = 2; vecs[3].tz = 8; vecs[3].ri = 9;
        vecs[3].coef = '{4, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0};
        vecs[3].n = 1;
        vecs[3].eb = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].el = '{5, 0, 0, 0, 0, 0, 0, 0};
        // Small block, zl 2 then 1
        vecs[4].tc = 3; vecs[4].tz = 2; vecs[4].ri = 4;
        vecs[4].coef = '{1, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4].n = 2;
        vecs[4].eb = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4].el = '{2, 1, 0, 0, 0, 0, 0, 0};
        // No emission: single coefficient
        vecs[5].tc = 1; vecs[5].tz = 3; vecs[5].ri = 3;
        vecs[5].coef = '{0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].n = 0;
        vecs[5].eb = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].el = '{0, 0, 0, 0, 0, 0, 0, 0};
        // No emission: no zeros
        vecs[6].tc = 5; vecs[6].tz = 0; vecs[6].ri = 4;
        vecs[6].coef = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6].n = 0;
        vecs[6].eb = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6].el = '{0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_bits", code_bit, 0);
        chk("rst_len", code_len, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) run_block(v, 1'b0, 1'b0);
        run_block(0, 1'b1, 1'b0);
        run_block(1, 1'b0, 1'b1);

        // Reset while the 3rd codeword of block A is presented.
        apply(0);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_cw3_valid", out_valid, 1);
        chk("mid_cw3_bits", code_bit, 3);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_bits", code_bit, 0);
        chk("mid_rst_len", code_len, 0);
        chk("mid_rst_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_done", done, 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", done, 0);
        run_block(1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
